// File: rtl/trainguard_pkg.sv
// Shared types and constants for the coach passenger counter front end.
// Holds the door FSM state enum, occupancy width and default limits.
package trainguard_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_BOTH,
        IN_B,
        OUT_A,
        OUT_BOTH,
        OUT_B,
        WAIT_CLEAR
    } door_state_t;

    localparam int OCC_W         = 4;
    localparam int DEF_LIMIT     = 5;
    localparam int DEF_MAX_COUNT = 15;

endpackage

// File: rtl/door_sensor_sequencer_if.sv
// Sensor inputs and event/occupancy outputs of the door sequencer.
// master: drives s1_raw/s2_raw, observes pulses, occupancy, over_limit.
// slave:  the sequencer side of the same signals.
interface door_sensor_sequencer_if;
    import trainguard_pkg::*;

    logic             s1_raw;
    logic             s2_raw;
    logic             entry_pulse;
    logic             exit_pulse;
    logic             error_pulse;
    logic [OCC_W-1:0] occupancy;
    logic             over_limit;

    modport master (
        output s1_raw, s2_raw,
        input  entry_pulse, exit_pulse, error_pulse,
        input  occupancy, over_limit
    );

    modport slave (
        input  s1_raw, s2_raw,
        output entry_pulse, exit_pulse, error_pulse,
        output occupancy, over_limit
    );

endinterface

// File: rtl/sensor_debounce.sv
// 2-FF synchronizer followed by a debounce counter for one beam sensor.
// Ports: clk, reset (async high), raw_i (async level), level_o (clean level).
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Level flips on the Nth consecutive differing sample; any
    // agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/door_sensor_sequencer.sv
// Turns two series beam sensors into entry/exit/error pulses and a
// saturating occupancy count with over-limit flag.
// Ports: clk, reset (async high), bus (slave side of the sensor interface).
module door_sensor_sequencer
    import trainguard_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int LIMIT           = DEF_LIMIT,
    parameter int MAX_COUNT       = DEF_MAX_COUNT
) (
    input  logic                    clk,
    input  logic                    reset,
    door_sensor_sequencer_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic             s1;
    logic             s2;
    logic [1:0]       s;
    door_state_t      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             entry_q, entry_d;
    logic             exit_q, exit_d;
    logic             error_q, error_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             over_q, over_d;
    logic             active;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk(clk), .reset(reset), .raw_i(bus.s1_raw), .level_o(s1)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clk(clk), .reset(reset), .raw_i(bus.s2_raw), .level_o(s2)
    );

    assign s = {s1, s2};

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s == 2'b10) state_d = IN_A;
                else if (s == 2'b01) state_d = OUT_A;
                else if (s == 2'b11) begin
                    state_d = WAIT_CLEAR;
                    error_d = 1'b1;
                end
            end
            IN_A: begin
                if (s == 2'b11) state_d = IN_BOTH;
                else if (s == 2'b00) state_d = IDLE;
            end
            IN_BOTH: begin
                if (s == 2'b01) state_d = IN_B;
                else if (s == 2'b10) state_d = IN_A;
                else if (s == 2'b00) begin
                    state_d = WAIT_CLEAR;
                    error_d = 1'b1;
                end
            end
            IN_B: begin
                if (s == 2'b00) begin
                    state_d = IDLE;
                    entry_d = 1'b1;
                end else if (s == 2'b11) state_d = IN_BOTH;
            end
            OUT_A: begin
                if (s == 2'b11) state_d = OUT_BOTH;
                else if (s == 2'b00) state_d = IDLE;
            end
            OUT_BOTH: begin
                if (s == 2'b10) state_d = OUT_B;
                else if (s == 2'b01) state_d = OUT_A;
                else if (s == 2'b00) begin
                    state_d = WAIT_CLEAR;
                    error_d = 1'b1;
                end
            end
            OUT_B: begin
                if (s == 2'b00) begin
                    state_d = IDLE;
                    exit_d  = 1'b1;
                end else if (s == 2'b11) state_d = OUT_BOTH;
            end
            WAIT_CLEAR: begin
                if (s == 2'b00) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Timer only runs while a sequence is in flight and restarts
        // whenever the sequence makes progress.
        active = (state_q != IDLE) && (state_q != WAIT_CLEAR);
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (active) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = WAIT_CLEAR;
                error_d = 1'b1;
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (entry_q && (occ_q != OCC_W'(MAX_COUNT))) begin
            occ_d = occ_q + 1'b1;
        end else if (exit_q && (occ_q != '0)) begin
            occ_d = occ_q - 1'b1;
        end
        over_d = (occ_d > OCC_W'(LIMIT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
            error_q <= 1'b0;
            occ_q   <= '0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            entry_q <= entry_d;
            exit_q  <= exit_d;
            error_q <= error_d;
            occ_q   <= occ_d;
            over_q  <= over_d;
        end
    end

    assign bus.entry_pulse = entry_q;
    assign bus.exit_pulse  = exit_q;
    assign bus.error_pulse = error_q;
    assign bus.occupancy   = occ_q;
    assign bus.over_limit  = over_q;

endmodule

// File: tb/tb_door_sensor_sequencer.sv
// Directed, table-driven bench for door_sensor_sequencer.
// Pulses are tallied every cycle; tallies and occupancy are checked per vector.
module tb_door_sensor_sequencer;

    typedef struct {
        bit s1;
        bit s2;
        int hold;
        int en;
        int ex;
        int er;
        int occ;
        bit ov;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n_en;
    int   n_ex;
    int   n_er;
    int   vid;
    vec_t vq[$];

    door_sensor_sequencer_if bus ();

    door_sensor_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally pulses and verify they never overlap.
    always @(negedge clk) begin
        if (!reset) begin
            n_en = n_en + int'(bus.entry_pulse);
            n_ex = n_ex + int'(bus.exit_pulse);
            n_er = n_er + int'(bus.error_pulse);
            checks = checks + 1;
            if (int'(bus.entry_pulse) + int'(bus.exit_pulse)
                + int'(bus.error_pulse) > 1) begin
                errors = errors + 1;
                $display("FAIL excl t=%0t en=%0b ex=%0b er=%0b want at most one",
                         $time, bus.entry_pulse, bus.exit_pulse,
                         bus.error_pulse);
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic void add(bit s1, bit s2, int hold,
                                int en, int ex, int er, int occ);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.hold = hold;
        v.en = en; v.ex = ex; v.er = er;
        v.occ = occ; v.ov = (occ > 5);
        vq.push_back(v);
    endfunction

    function automatic void add_entry(int en, int ex, int er,
                                      int ob, int oa);
        add(1, 0, 10, en, ex, er, ob);
        add(1, 1, 10, en, ex, er, ob);
        add(0, 1, 10, en, ex, er, ob);
        add(0, 0, 10, en + 1, ex, er, oa);
    endfunction

    function automatic void add_exit(int en, int ex, int er,
                                     int ob, int oa);
        add(0, 1, 10, en, ex, er, ob);
        add(1, 1, 10, en, ex, er, ob);
        add(1, 0, 10, en, ex, er, ob);
        add(0, 0, 10, en, ex + 1, er, oa);
    endfunction

    task automatic run_table();
        foreach (vq[i]) begin
            bus.s1_raw = vq[i].s1;
            bus.s2_raw = vq[i].s2;
            repeat (vq[i].hold) @(posedge clk);
            #1;
            chk($sformatf("v%0d entries", vid), n_en, vq[i].en);
            chk($sformatf("v%0d exits", vid), n_ex, vq[i].ex);
            chk($sformatf("v%0d errors", vid), n_er, vq[i].er);
            chk($sformatf("v%0d occupancy", vid),
                int'(bus.occupancy), vq[i].occ);
            chk($sformatf("v%0d over_limit", vid),
                int'(bus.over_limit), int'(vq[i].ov));
            vid = vid + 1;
        end
        vq.delete();
    endtask

    initial begin
        checks = 0; errors = 0;
        n_en = 0; n_ex = 0; n_er = 0; vid = 0;
        reset = 1'b1;
        bus.s1_raw = 1'b0;
        bus.s2_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst occupancy", int'(bus.occupancy), 0);
        chk("rst over_limit", int'(bus.over_limit), 0);
        chk("rst entry", int'(bus.entry_pulse), 0);
        chk("rst exit", int'(bus.exit_pulse), 0);
        chk("rst error", int'(bus.error_pulse), 0);
        reset = 1'b0;

        // Six entries, then one exit.
        for (int k = 1; k <= 6; k++) add_entry(k - 1, 0, 0, k - 1, k);
        add_exit(6, 0, 0, 6, 5);
        // Backed-out entry: no events.
        add(1, 0, 10, 6, 1, 0, 5);
        add(1, 1, 10, 6, 1, 0, 5);
        add(1, 0, 10, 6, 1, 0, 5);
        add(0, 0, 10, 6, 1, 0, 5);
        // Both rise together: one error, nothing until clear.
        add(1, 1, 10, 6, 1, 1, 5);
        add(0, 1, 10, 6, 1, 1, 5);
        add(0, 0, 10, 6, 1, 1, 5);
        add_exit(6, 1, 1, 5, 4);
        // s1 held past the timeout, then released.
        add(1, 0, 100, 6, 2, 2, 4);
        add(0, 0, 10, 6, 2, 2, 4);
        // Entry up to IN_B, then a short s2 dropout.
        add(1, 0, 10, 6, 2, 2, 4);
        add(1, 1, 10, 6, 2, 2, 4);
        add(0, 1, 10, 6, 2, 2, 4);
        run_table();

        bus.s2_raw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.s2_raw = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("glitch entries", n_en, 6);
        chk("glitch errors", n_er, 2);
        chk("glitch occupancy", int'(bus.occupancy), 4);

        add(0, 0, 10, 7, 2, 2, 5);
        // Walk into IN_BOTH for the reset test.
        add(1, 0, 10, 7, 2, 2, 5);
        add(1, 1, 10, 7, 2, 2, 5);
        run_table();

        reset = 1'b1;
        #1;
        chk("midrst occupancy", int'(bus.occupancy), 0);
        chk("midrst over_limit", int'(bus.over_limit), 0);
        chk("midrst pulses", int'(bus.entry_pulse) + int'(bus.exit_pulse)
            + int'(bus.error_pulse), 0);
        bus.s1_raw = 1'b0;
        bus.s2_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("postrst entries", n_en, 7);
        chk("postrst exits", n_ex, 2);
        chk("postrst errors", n_er, 2);
        chk("postrst occupancy", int'(bus.occupancy), 0);

        // Exit from empty, then 16 entries saturating at 15.
        add_exit(7, 2, 2, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            add_entry(6 + k, 3, 2, (k - 1 > 15) ? 15 : k - 1,
                      (k > 15) ? 15 : k);
        end
        run_table();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
